mult_share_arbiter: RTL

//   Shares one pipelined signed N x N multiplier among NREQ requesters.

---
 rtl/mult_share_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one pipelined signed N x N multiplier among NREQ
// requesters; products return tagged with the issuing requester's index.
module mult_share_arbiter #(
    parameter int N    = 32,
    parameter int NREQ = 4,
    parameter int LAT  = 2,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*N-1:0]   req_a,
    input  logic [NREQ*N-1:0]   req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic                rsp_valid,
    output logic [IDW-1:0]      rsp_id,
    output logic [2*N-1:0]      rsp_result,
    input  logic                rsp_ready,
    output logic                busy
);

    // Stage holding the first product register: with a single stage the
    // multiply sits in front of the only (output) register.
    localparam int PS = (LAT == 1) ? 1 : 2;

    logic [LAT:1]     valid_reg;
    logic [IDW-1:0]   id_reg   [1:LAT];
    logic [2*N-1:0]   prod_reg [PS:LAT];
    logic [IDW-1:0]   ptr_reg;
    logic [IDW-1:0]   ptr_next;

    logic             advance;
    logic             found;
    logic             transfer;
    logic [IDW-1:0]   gnt_idx;
    logic [N-1:0]     sel_a;
    logic [N-1:0]     sel_b;
    logic [2*N-1:0]   mul_a;
    logic [2*N-1:0]   mul_b;
    logic             mul_load;

    assign advance  = !valid_reg[LAT] | rsp_ready;
    assign transfer = advance & found;

    // First requester at or above the pointer, wrapping modulo NREQ.
    always_comb begin
        int idx;
        found   = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_reg) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found   = 1'b1;
                gnt_idx = IDW'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (transfer) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (transfer) begin
            ptr_next = IDW'((int'(gnt_idx) + 1) % NREQ);
        end
    end

    assign sel_a = req_a[int'(gnt_idx)*N +: N];
    assign sel_b = req_b[int'(gnt_idx)*N +: N];

    generate
        if (LAT == 1) begin : g_direct
            assign mul_a    = {{N{sel_a[N-1]}}, sel_a};
            assign mul_b    = {{N{sel_b[N-1]}}, sel_b};
            assign mul_load = transfer;
        end else begin : g_opreg
            logic [N-1:0] a_reg;
            logic [N-1:0] b_reg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    a_reg <= '0;
                    b_reg <= '0;
                end else if (transfer) begin
                    a_reg <= sel_a;
                    b_reg <= sel_b;
                end
            end
            assign mul_a    = {{N{a_reg[N-1]}}, a_reg};
            assign mul_b    = {{N{b_reg[N-1]}}, b_reg};
            assign mul_load = valid_reg[1];
        end
    endgenerate

    // Data and IDs load only behind a valid op, so the output keeps the last
    // product while bubbles pass through.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_reg   <= '0;
            valid_reg <= '0;
            for (int k = 1; k <= LAT; k++) begin
                id_reg[k] <= '0;
            end
            for (int k = PS; k <= LAT; k++) begin
                prod_reg[k] <= '0;
            end
        end else begin
            ptr_reg <= ptr_next;
            if (advance) begin
                valid_reg[1] <= transfer;
                if (transfer) begin
                    id_reg[1] <= gnt_idx;
                end
                for (int k = 2; k <= LAT; k++) begin
                    valid_reg[k] <= valid_reg[k-1];
                    if (valid_reg[k-1]) begin
                        id_reg[k] <= id_reg[k-1];
                    end
                end
                if (mul_load) begin
                    prod_reg[PS] <= mul_a * mul_b;
                end
                for (int k = PS + 1; k <= LAT; k++) begin
                    if (valid_reg[k-1]) begin
                        prod_reg[k] <= prod_reg[k-1];
                    end
                end
            end
        end
    end

    assign rsp_valid  = valid_reg[LAT];
    assign rsp_id     = id_reg[LAT];
    assign rsp_result = prod_reg[LAT];
    assign busy       = |valid_reg;

endmodule
